vga_timing_gen: RTL and testbench

- Raster timing source for the overlay/draw pipeline.
- Produces the pixel coordinates clk_x/clk_y consumed by the overlay region decoders, plus hsync, vsync, active-video and frame/line strobes.
- One pixel per clock. Default timing is 800x600@60 with a 40 MHz pixel clock.
- Sits at the head of the display path. All DRAW_* blocks and the video DAC/encoder are fed from it.

---
 rtl/vga_timing_pkg.sv | 30 +++
 rtl/vga_axis_cnt.sv | 47 ++++
 rtl/vga_timing_gen.sv | 109 ++++++++++
 tb/tb_vga_timing_gen.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared raster constants: default 800x600@60 timing, coordinate widths, overlay bounds.
// Imported by the timing generator and the DRAW_* region decoders.
package vga_timing_pkg;

   localparam int H_ACTIVE_DEF = 800;
   localparam int H_FP_DEF     = 40;
   localparam int H_SYNC_DEF   = 128;
   localparam int H_BP_DEF     = 88;
   localparam int V_ACTIVE_DEF = 600;
   localparam int V_FP_DEF     = 1;
   localparam int V_SYNC_DEF   = 4;
   localparam int V_BP_DEF     = 23;

   localparam int X_W = 11;
   localparam int Y_W = 10;

   function automatic int axis_total(input int act, input int fp, input int sync, input int bp);
      return act + fp + sync + bp;
   endfunction

   localparam int H_TOTAL_DEF = axis_total(H_ACTIVE_DEF, H_FP_DEF, H_SYNC_DEF, H_BP_DEF);
   localparam int V_TOTAL_DEF = axis_total(V_ACTIVE_DEF, V_FP_DEF, V_SYNC_DEF, V_BP_DEF);

   // Overlay window bounds used by the region decoders (inclusive, active-area coordinates)
   localparam int OVL_COL_L = 16;
   localparam int OVL_COL_R = 783;
   localparam int OVL_ROW_T = 16;
   localparam int OVL_ROW_B = 583;

endpackage

// File: rtl/vga_axis_cnt.sv
// One raster axis: wrapping position counter plus combinational decode of its next value.
// Advances only when adv is high; the decodes are meant to be registered by the caller.
module vga_axis_cnt #(
   parameter int ACTIVE = 800,
   parameter int FP     = 40,
   parameter int SYNC   = 128,
   parameter int BP     = 88,
   parameter bit POL    = 1'b1,
   parameter int W      = 11
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         adv,
   output logic [W-1:0] cnt_nxt,
   output logic         sync_nxt,
   output logic         act_nxt,
   output logic         zero_nxt
);

   localparam int TOTAL = ACTIVE + FP + SYNC + BP;
   localparam logic [W-1:0] LAST    = W'(TOTAL - 1);
   localparam logic [W-1:0] SYNC_LO = W'(ACTIVE + FP);
   localparam logic [W-1:0] SYNC_HI = W'(ACTIVE + FP + SYNC - 1);
   localparam logic [W-1:0] ACT_END = W'(ACTIVE);

   logic [W-1:0] cnt_q;

   // Parked on the last position so the first advance after reset lands on zero
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q <= LAST;
      end else if (adv) begin
         cnt_q <= cnt_nxt;
      end
   end

   always_comb begin
      cnt_nxt = cnt_q;
      if (adv) begin
         cnt_nxt = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
      end
      sync_nxt = (cnt_nxt >= SYNC_LO && cnt_nxt <= SYNC_HI) ? POL : ~POL;
      act_nxt  = (cnt_nxt < ACT_END);
      zero_nxt = (cnt_nxt == '0);
   end

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing source: pixel coordinates, syncs, active video and line/frame strobes, all registered together.
// One pixel per clock; with VGA_TIMING_CE_EN defined, everything advances only on pix_ce.
module vga_timing_gen
   import vga_timing_pkg::*;
#(
   parameter int H_ACTIVE = H_ACTIVE_DEF,
   parameter int H_FP     = H_FP_DEF,
   parameter int H_SYNC   = H_SYNC_DEF,
   parameter int H_BP     = H_BP_DEF,
   parameter int V_ACTIVE = V_ACTIVE_DEF,
   parameter int V_FP     = V_FP_DEF,
   parameter int V_SYNC   = V_SYNC_DEF,
   parameter int V_BP     = V_BP_DEF,
   parameter bit HS_POL   = 1'b1,
   parameter bit VS_POL   = 1'b1
) (
   input  logic           clk,
   input  logic           reset,
`ifdef VGA_TIMING_CE_EN
   input  logic           pix_ce,
`endif
   output logic [X_W-1:0] clk_x,
   output logic [Y_W-1:0] clk_y,
   output logic           hsync,
   output logic           vsync,
   output logic           active,
   output logic           line_start,
   output logic           frame_start
);

   localparam int H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
   localparam int V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

   if (H_TOTAL > 2048 || V_TOTAL > 1024) begin : g_bad_timing
      $fatal(1, "vga_timing_gen: raster totals exceed coordinate width");
   end

   logic ce;
`ifdef VGA_TIMING_CE_EN
   assign ce = pix_ce;
`else
   assign ce = 1'b1;
`endif

   logic [X_W-1:0] h_nxt;
   logic [Y_W-1:0] v_nxt;
   logic           h_sync_nxt, h_act_nxt, h_zero_nxt;
   logic           v_sync_nxt, v_act_nxt, v_zero_nxt;
   logic           v_adv;

   // The line counter steps on the same edge the pixel counter wraps to zero
   assign v_adv = ce & h_zero_nxt;

   vga_axis_cnt #(
      .ACTIVE (H_ACTIVE),
      .FP     (H_FP),
      .SYNC   (H_SYNC),
      .BP     (H_BP),
      .POL    (HS_POL),
      .W      (X_W)
   ) u_h_cnt (
      .clk      (clk),
      .reset    (reset),
      .adv      (ce),
      .cnt_nxt  (h_nxt),
      .sync_nxt (h_sync_nxt),
      .act_nxt  (h_act_nxt),
      .zero_nxt (h_zero_nxt)
   );

   vga_axis_cnt #(
      .ACTIVE (V_ACTIVE),
      .FP     (V_FP),
      .SYNC   (V_SYNC),
      .BP     (V_BP),
      .POL    (VS_POL),
      .W      (Y_W)
   ) u_v_cnt (
      .clk      (clk),
      .reset    (reset),
      .adv      (v_adv),
      .cnt_nxt  (v_nxt),
      .sync_nxt (v_sync_nxt),
      .act_nxt  (v_act_nxt),
      .zero_nxt (v_zero_nxt)
   );

   // Every output is loaded from the same next-count decode, so they never skew
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         clk_x       <= '0;
         clk_y       <= '0;
         hsync       <= ~HS_POL;
         vsync       <= ~VS_POL;
         active      <= 1'b0;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
      end else if (ce) begin
         clk_x       <= h_nxt;
         clk_y       <= v_nxt;
         hsync       <= h_sync_nxt;
         vsync       <= v_sync_nxt;
         active      <= h_act_nxt & v_act_nxt;
         line_start  <= h_zero_nxt;
         frame_start <= h_zero_nxt & v_zero_nxt;
      end
   end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default-timing instance for line checks, small-raster instance for frame checks.
// A per-cycle reference model feeds scoreboards; directed steps check the raster landmarks.
module tb_vga_timing_gen;

   typedef struct packed {
      logic [10:0] x;
      logic [9:0]  y;
      logic        hs;
      logic        vs;
      logic        act;
      logic        ls;
      logic        fs;
   } obs_t;

   logic clk = 1'b0;
   logic rst0 = 1'b0;
   logic rst1 = 1'b0;
   logic ce = 1'b1;

   logic [10:0] d0_x, d1_x;
   logic [9:0]  d0_y, d1_y;
   logic        d0_hs, d0_vs, d0_act, d0_ls, d0_fs;
   logic        d1_hs, d1_vs, d1_act, d1_ls, d1_fs;

   int n_assert = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   vga_timing_gen u_dut0 (
      .clk         (clk),
      .reset       (rst0),
`ifdef VGA_TIMING_CE_EN
      .pix_ce      (ce),
`endif
      .clk_x       (d0_x),
      .clk_y       (d0_y),
      .hsync       (d0_hs),
      .vsync       (d0_vs),
      .active      (d0_act),
      .line_start  (d0_ls),
      .frame_start (d0_fs)
   );

   vga_timing_gen #(
      .H_ACTIVE (16), .H_FP (4), .H_SYNC (8), .H_BP (4),
      .V_ACTIVE (12), .V_FP (1), .V_SYNC (4), .V_BP (3),
      .HS_POL   (1'b0), .VS_POL (1'b0)
   ) u_dut1 (
      .clk         (clk),
      .reset       (rst1),
`ifdef VGA_TIMING_CE_EN
      .pix_ce      (ce),
`endif
      .clk_x       (d1_x),
      .clk_y       (d1_y),
      .hsync       (d1_hs),
      .vsync       (d1_vs),
      .active      (d1_act),
      .line_start  (d1_ls),
      .frame_start (d1_fs)
   );

   // Reference model state, one entry per instance
   int   mx [2];
   int   my [2];
   obs_t cur [2];
   obs_t sb0 [$];
   obs_t sb1 [$];

   function automatic void geom(input int d, output int ha, output int hf, output int hsw, output int ht,
                                output int va, output int vf, output int vsw, output int vt,
                                output bit hp, output bit vp);
      if (d == 0) begin
         ha = 800; hf = 40; hsw = 128; ht = 1056; va = 600; vf = 1; vsw = 4; vt = 628; hp = 1; vp = 1;
      end else begin
         ha = 16; hf = 4; hsw = 8; ht = 32; va = 12; vf = 1; vsw = 4; vt = 20; hp = 0; vp = 0;
      end
   endfunction

   function automatic obs_t reset_obs(input int d);
      obs_t o;
      o = '0;
      o.hs = (d == 0) ? 1'b0 : 1'b1;
      o.vs = (d == 0) ? 1'b0 : 1'b1;
      return o;
   endfunction

   function automatic obs_t decode(input int d, input int x, input int y);
      int ha, hf, hsw, ht, va, vf, vsw, vt;
      bit hp, vp;
      obs_t o;
      geom(d, ha, hf, hsw, ht, va, vf, vsw, vt, hp, vp);
      o.x   = 11'(x);
      o.y   = 10'(y);
      o.hs  = (x >= ha + hf && x <= ha + hf + hsw - 1) ? hp : !hp;
      o.vs  = (y >= va + vf && y <= va + vf + vsw - 1) ? vp : !vp;
      o.act = (x < ha) && (y < va);
      o.ls  = (x == 0);
      o.fs  = (x == 0) && (y == 0);
      return o;
   endfunction

   function automatic obs_t obs(input int d);
      if (d == 0) return {d0_x, d0_y, d0_hs, d0_vs, d0_act, d0_ls, d0_fs};
      return {d1_x, d1_y, d1_hs, d1_vs, d1_act, d1_ls, d1_fs};
   endfunction

   task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
      n_assert++;
      assert (o === e) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
      end
   endtask

   // Push the model's post-edge expectation, clock once, then compare at the falling edge
   task automatic tick();
      int ha, hf, hsw, ht, va, vf, vsw, vt;
      bit hp, vp;
      obs_t e;
      for (int d = 0; d < 2; d++) begin
         geom(d, ha, hf, hsw, ht, va, vf, vsw, vt, hp, vp);
         if (((d == 0) ? rst0 : rst1) == 1'b0) begin
            mx[d]  = ht - 1;
            my[d]  = vt - 1;
            cur[d] = reset_obs(d);
         end else if (ce) begin
            mx[d] = (mx[d] == ht - 1) ? 0 : mx[d] + 1;
            if (mx[d] == 0) my[d] = (my[d] == vt - 1) ? 0 : my[d] + 1;
            cur[d] = decode(d, mx[d], my[d]);
         end
         if (d == 0) sb0.push_back(cur[d]);
         else        sb1.push_back(cur[d]);
      end
      @(posedge clk);
      @(negedge clk);
      e = sb0.pop_front();
      chk("sb0", 64'(obs(0)), 64'(e));
      e = sb1.pop_front();
      chk("sb1", 64'(obs(1)), 64'(e));
   endtask

   task automatic run_to(input int d, input int x, input int y, input int lim, input string tag);
      int n;
      n = 0;
      while (!(obs(d).x == 11'(x) && obs(d).y == 10'(y)) && n < lim) begin
         tick();
         n++;
      end
      chk(tag, 64'(obs(d).x == 11'(x) && obs(d).y == 10'(y)), 64'd1);
   endtask

   initial begin
      int n;
      mx[0] = 1055; my[0] = 627; mx[1] = 31; my[1] = 19;
      cur[0] = reset_obs(0); cur[1] = reset_obs(1);
      repeat (3) @(negedge clk);
      chk("reset0", 64'(obs(0)), 64'(reset_obs(0)));
      chk("reset1", 64'(obs(1)), 64'(reset_obs(1)));

      rst0 = 1'b1;
      rst1 = 1'b1;
      tick();
      chk("first_edge0", 64'(obs(0)), 64'({11'd0, 10'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1}));
      chk("first_edge1", 64'(obs(1)), 64'({11'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1}));

      // Horizontal landmarks on the default 800x600 raster
      run_to(0, 799, 0, 2000, "reach_799");
      chk("x799_active", 64'(d0_act), 64'd1);
      tick();
      chk("x800", 64'({d0_x, d0_y, d0_act}), 64'({11'd800, 10'd0, 1'b0}));
      run_to(0, 839, 0, 2000, "reach_839");
      chk("hs_839", 64'(d0_hs), 64'd0);
      tick();
      chk("hs_840", 64'(d0_hs), 64'd1);
      n = 0;
      while (d0_hs === 1'b1 && n < 300) begin
         n++;
         tick();
      end
      chk("hs_width", 64'(n), 64'd128);
      chk("hs_off_at", 64'(d0_x), 64'd968);
      run_to(0, 1055, 5, 8000, "reach_1055_5");
      tick();
      chk("line_wrap", 64'({d0_x, d0_y, d0_ls, d0_fs}), 64'({11'd0, 10'd6, 1'b1, 1'b0}));

      // Frame-level behaviour on the 32x20 raster
      run_to(1, 31, 19, 1000, "reach_frame_end");
      tick();
      chk("frame_wrap", 64'({d1_x, d1_y, d1_fs}), 64'({11'd0, 10'd0, 1'b1}));
      n = 0;
      do begin
         tick();
         n++;
      end while (d1_fs !== 1'b1 && n < 2000);
      chk("frame_period", 64'(n), 64'd640);
      run_to(1, 31, 12, 1000, "reach_31_12");
      chk("vs_before", 64'(d1_vs), 64'd1);
      tick();
      chk("vs_on", 64'({d1_x, d1_y, d1_vs}), 64'({11'd0, 10'd13, 1'b0}));
      n = 0;
      while (d1_vs === 1'b0 && n < 500) begin
         n++;
         tick();
      end
      chk("vs_width", 64'(n), 64'd128);
      chk("vs_off_at", 64'({d1_x, d1_y}), 64'({11'd0, 10'd17}));

      // Asynchronous reset mid-frame, then clean restart at the frame origin
      run_to(1, 10, 7, 1000, "reach_10_7");
      rst1 = 1'b0;
      #1;
      chk("async_reset", 64'(obs(1)), 64'(reset_obs(1)));
      tick();
      tick();
      rst1 = 1'b1;
      tick();
      chk("restart", 64'(obs(1)), 64'({11'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1}));
      tick();
      chk("restart_next", 64'({d1_x, d1_fs, d1_ls}), 64'({11'd1, 1'b0, 1'b0}));

`ifdef VGA_TIMING_CE_EN
      rst1 = 1'b0;
      tick();
      rst1 = 1'b1;
      ce = 1'b0;
      tick();
      chk("ce_hold_reset", 64'(obs(1)), 64'(reset_obs(1)));
      ce = 1'b1;
      tick();
      chk("ce_first", 64'({d1_x, d1_y, d1_fs}), 64'({11'd0, 10'd0, 1'b1}));
      ce = 1'b0;
      tick();
      chk("ce_fs_held", 64'({d1_x, d1_fs}), 64'({11'd0, 1'b1}));
      ce = 1'b1;
      tick();
      chk("ce_x1", 64'({d1_x, d1_fs}), 64'({11'd1, 1'b0}));
      ce = 1'b0;
      tick();
      chk("ce_x1_held", 64'(d1_x), 64'd1);
      ce = 1'b1;
      tick();
      chk("ce_x2", 64'(d1_x), 64'd2);
`endif

      repeat (4) tick();
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
